// File: rtl/cardinal_nic.sv
// Memory-mapped NIC: one-packet input buffer and output channel between the processor and a router port.
// Define CARDINAL_NIC_OUT_FIFO_EN to turn the output channel into a 2-entry FIFO.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  logic [0:DATA_WIDTH-1] icb;
  logic                  ics;

  logic [0:DATA_WIDTH-1] out_head;
  logic                  out_valid;
  logic                  out_full;
  logic                  inject;
  logic                  wr_out;
  logic                  rd_in;
  logic [0:DATA_WIDTH-1] status;

`ifdef CARDINAL_NIC_OUT_FIFO_EN
  logic [0:DATA_WIDTH-1] fifo_mem [0:1];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  assign out_head  = fifo_mem[rd_ptr];
  assign out_valid = (count != 2'd0);
  assign out_full  = (count == 2'd2);
`else
  logic [0:DATA_WIDTH-1] ocb;
  logic                  ocs;

  assign out_head  = ocb;
  assign out_valid = ocs;
  assign out_full  = ocs;
`endif

  assign net_ri = ~Reset & ~ics;
  assign inject = out_valid & net_ro & (out_head[0] == net_polarity);
  assign wr_out = nicEn & nicWrEn & (addr == 2'b10) & ~out_full;
  assign rd_in  = nicEn & ~nicWrEn & (addr == 2'b00);

  always_comb begin
    status = '0;
    status[DATA_WIDTH-1] = out_full;
`ifdef CARDINAL_NIC_OUT_FIFO_EN
    status[DATA_WIDTH-2] = out_valid;
`endif
    d_out = '0;
    if (!Reset && nicEn && !nicWrEn) begin
      case (addr)
        2'b00:   d_out = icb;
        2'b01:   d_out = {{(DATA_WIDTH-1){1'b0}}, ics};
        2'b10:   d_out = out_head;
        2'b11:   d_out = status;
        default: d_out = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      icb    <= '0;
      ics    <= 1'b0;
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      // receive and a clearing read of 00 are mutually exclusive since net_ri=~ics
      if (net_si && net_ri) begin
        icb <= net_di;
        ics <= 1'b1;
      end else if (rd_in && ics) begin
        ics <= 1'b0;
      end
      net_so <= inject;
      if (inject) net_do <= out_head;
    end
  end

`ifdef CARDINAL_NIC_OUT_FIFO_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_out) begin
        fifo_mem[wr_ptr] <= d_in;
        wr_ptr           <= ~wr_ptr;
      end
      if (inject) rd_ptr <= ~rd_ptr;
      case ({wr_out, inject})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
`else
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ocb <= '0;
      ocs <= 1'b0;
    end else if (inject) begin
      ocs <= 1'b0;
    end else if (wr_out) begin
      ocb <= d_in;
      ocs <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cardinal_nic.sv
// Testbench for cardinal_nic: directed scenarios plus randomized traffic against a queue-based reference model.
// Honours CARDINAL_NIC_OUT_FIFO_EN to select the output-channel model.
module tb_cardinal_nic;

`ifdef CARDINAL_NIC_OUT_FIFO_EN
  localparam int CAP  = 2;
  localparam bit FIFO = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit FIFO = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .Clock(Clock), .Reset(Reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 Clock = ~Clock;

  // reference model: input slot, output queue of capacity CAP, last injected packet
  logic [63:0] m_icb = '0;
  bit          m_ics = 1'b0;
  logic [63:0] m_ocb = '0;
  logic [63:0] q[$];
  bit          m_so = 1'b0;
  logic [63:0] m_do = '0;

  int          total = 0;
  int          bad = 0;
  logic [63:0] dout_seen;
  logic        so_seen;
  logic        ri_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit we, input logic [1:0] a,
                      input logic [63:0] din, input bit si, input logic [63:0] di,
                      input bit ro, input bit pol);
    logic [63:0] exp_d;
    bit known, inj, wr, rx, rd;
    Reset = rst; nicEn = en; nicWrEn = we; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    #2;
    known = 1'b1;
    exp_d = '0;
    if (!rst && en && !we) begin
      case (a)
        2'd0: exp_d = m_icb;
        2'd1: exp_d = 64'(m_ics);
        2'd2: begin
          if (!FIFO) exp_d = m_ocb;
          else if (q.size() > 0) exp_d = q[0];
          else known = 1'b0;
        end
        default: exp_d = FIFO ? {62'b0, q.size() > 0, q.size() == CAP} : 64'(q.size() == 1);
      endcase
    end
    dout_seen = d_out;
    ri_seen   = net_ri;
    if (known) check("d_out", d_out, exp_d);
    check("net_ri", 64'(net_ri), 64'(!rst && !m_ics));
    @(posedge Clock);
    if (rst) begin
      m_icb = '0; m_ics = 1'b0; m_ocb = '0; q.delete(); m_so = 1'b0; m_do = '0;
    end else begin
      inj = (q.size() > 0) && ro && (q[0][63] == pol);
      wr  = en && we && (a == 2'd2) && (q.size() < CAP);
      rx  = si && !m_ics;
      rd  = en && !we && (a == 2'd0);
      m_so = inj;
      if (inj) m_do = q.pop_front();
      if (wr) begin
        q.push_back(din);
        m_ocb = din;
      end
      if (rx) begin
        m_icb = di;
        m_ics = 1'b1;
      end else if (rd) begin
        m_ics = 1'b0;
      end
    end
    #1;
    so_seen = net_so;
    check("net_so", 64'(net_so), 64'(m_so));
    check("net_do", net_do, m_do);
  endtask

  task automatic idle(input bit ro, input bit pol);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, '0, ro, pol);
  endtask

  task automatic wr10(input logic [63:0] v, input bit ro, input bit pol);
    step(1'b0, 1'b1, 1'b1, 2'd2, v, 1'b0, '0, ro, pol);
  endtask

  task automatic rdreg(input logic [1:0] a, input bit ro, input bit pol);
    step(1'b0, 1'b1, 1'b0, a, '0, 1'b0, '0, ro, pol);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd1, '0, 1'b1, 64'hFFFF, 1'b1, 1'b0);
    check("rst_dout", dout_seen, 64'h0);
    check("rst_so", 64'(so_seen), 64'h0);

    // receive path
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0);
    rdreg(2'd1, 1'b0, 1'b0);
    check("ics_full_ri", 64'(ri_seen), 64'h0);
    check("rd01", dout_seen, 64'h1);
    rdreg(2'd0, 1'b0, 1'b0);
    check("rd00", dout_seen, 64'hA5A5_0000_0000_0001);
    idle(1'b0, 1'b0);
    check("ri_after_rd", 64'(ri_seen), 64'h1);

    // injection gated by polarity
    wr10(64'h8000_0000_0000_00FF, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("no_inj_pol", 64'(so_seen), 64'h0);
    idle(1'b1, 1'b1);
    check("inj_so", 64'(so_seen), 64'h1);
    check("inj_do", net_do, 64'h8000_0000_0000_00FF);
    rdreg(2'd3, 1'b1, 1'b1);
    check("rd11_empty", dout_seen, 64'h0);
    check("so_one_cycle", 64'(so_seen), 64'h0);

    // write while output occupied and router busy
    wr10(64'h7, 1'b0, 1'b0);
    wr10(64'h1234, 1'b0, 1'b0);
    rdreg(2'd2, 1'b0, 1'b0);
    check("rd10_keep", dout_seen, 64'h7);
    repeat (3) idle(1'b1, 1'b0);

    // injection edge coinciding with a write
    wr10(64'h9, 1'b0, 1'b0);
    wr10(64'h5, 1'b1, 1'b0);
    check("coinc_inj", net_do, 64'h9);
    rdreg(2'd3, 1'b0, 1'b0);
    check("coinc_status", dout_seen, FIFO ? 64'h2 : 64'h0);
    repeat (2) idle(1'b1, 1'b0);

    // reset right after loading the output channel
    wr10(64'h3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b1, 1'b0);
    repeat (3) begin
      idle(1'b1, 1'b0);
      check("rst_no_send", 64'(so_seen), 64'h0);
    end
    rdreg(2'd3, 1'b1, 1'b0);
    check("rst_status", dout_seen, 64'h0);

`ifdef CARDINAL_NIC_OUT_FIFO_EN
    wr10(64'h1, 1'b0, 1'b0);
    wr10(64'h2, 1'b0, 1'b0);
    wr10(64'h3, 1'b0, 1'b0);
    rdreg(2'd3, 1'b0, 1'b0);
    check("fifo_full", dout_seen, 64'h3);
    idle(1'b1, 1'b0);
    check("fifo_first", net_do, 64'h1);
    idle(1'b1, 1'b0);
    check("fifo_second", net_do, 64'h2);
    idle(1'b1, 1'b0);
    check("fifo_drained", 64'(so_seen), 64'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), {$urandom(), $urandom()}, 1'($urandom_range(0, 2) == 0),
           {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Memory-mapped network interface on the processor's data-memory port.
- Address decode upstream routes a 2-bit register offset here.
- Buffers one 64-bit packet per direction between the processor and the local router port, with a ready/send handshake on the router side.
- Output injection is gated by the router's virtual-channel polarity.

Parameters:
- DATA_WIDTH, 64, packet and processor data width.
- ADDR_WIDTH, 2, register offset width.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- addr  input  [0:1]  register offset: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  [0:63]  processor store data.
- d_out  output  [0:63]  processor load data; combinational.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn.
- net_si  input  1  router sending a packet this cycle.
- net_ri  output  1  NIC able to accept a packet.
- net_di  input  [0:63]  packet from router.
- net_so  output  1  NIC sending a packet this cycle; registered.
- net_ro  input  1  router able to accept a packet.
- net_do  output  [0:63]  packet to router; registered.
- net_polarity  input  1  current router VC phase.

Behaviour:
- Bit order is big-endian: [0] is MSB, [63] is LSB. Packet bit [0] is the VC bit.
- Internal state:
  - ICB: 64-bit input buffer, with flag ICS (1 = full).
  - OCB: 64-bit output buffer, with flag OCS (1 = full).
- Reset: ICB=0, ICS=0, OCB=0, OCS=0, net_so=0, net_do=0. While Reset is high, net_ri=0 and d_out=0.
- net_ri = ~ICS when not in reset (combinational).
- Receive: at a posedge with net_si && net_ri, ICB<=net_di and ICS<=1. net_si while net_ri=0 is ignored; the packet is not captured.
- Processor read (nicEn && !nicWrEn), d_out valid in the same cycle:
  - 00 returns ICB.
  - 01 returns {63'b0, ICS}.
  - 10 returns OCB.
  - 11 returns {63'b0, OCS}.
  - d_out=0 when nicEn=0 or nicWrEn=1.
- A read of 00 while ICS=1 clears ICS at the next posedge.
  - A read of 00 while ICS=0 returns stale ICB and has no side effect.
  - ICB is not cleared by the read.
- Processor write (nicEn && nicWrEn):
  - Offset 10 with OCS=0: OCB<=d_in and OCS<=1 at the posedge.
  - Offset 10 with OCS=1: write dropped silently.
  - Writes to 00, 01 and 11: ignored.
- Injection: at a posedge with OCS && net_ro && (OCB[0]==net_polarity):
  - net_so<=1 and net_do<=OCB.
  - OCS<=0.
  - Otherwise net_so<=0; net_do holds its last value.
- net_so pulses exactly one cycle per packet. Latency from OCS set to net_so is 1 cycle minimum when the gating conditions already hold.
- Simultaneous events:
  - Injection and processor write to 10 in the same cycle: the write is dropped, because OCS is sampled before the edge.
  - Receive and read of 00 cannot coincide, since net_ri=0 whenever ICS=1.
  - Read of 01/11 in the same cycle a flag changes returns the pre-edge value.
- Reset mid-operation: any buffered packet is discarded. net_so falls on the reset edge.

Optional Feature:
- Macro: CARDINAL_NIC_OUT_FIFO_EN.
- When defined:
  - The output channel is a 2-entry FIFO.
  - Offset 10 writes push when not full; a write when full is dropped.
  - Injection pops the head under the same net_ro/polarity rule, checking head bit [0].
  - Offset 11 returns full in bit [63] and non-empty in bit [62].
  - Offset 10 read returns the head.
  - A push and a pop in the same cycle are both performed when the FIFO is neither empty nor full.
- When undefined: single OCB as above, with offset 11 bits [0:62]=0.

Test Plan:
- Reset, then net_si=1 with net_di=64'hA5A5_0000_0000_0001:
  - Next cycle ICS=1 and net_ri=0.
  - Read 01 returns 64'h1.
  - Read 00 returns A5A5_0000_0000_0001.
  - Next cycle ICS=0 and net_ri=1.
- Write 10 with 64'h8000_0000_0000_00FF, net_ro=1, net_polarity=0: no injection while polarity mismatches. Then polarity=1: one-cycle net_so=1 with net_do=8000_0000_0000_00FF, and read 11 afterwards returns 0.
- OCS=1 with net_ro=0, then write 10 with 64'h1234: OCB is unchanged and read 10 returns the original packet.
- Injection edge coinciding with a write to 10 of 64'h5: write dropped, OCS=0 after the edge.
- Reset asserted the cycle after OCB is loaded: OCS=0, net_so=0, and no packet is ever sent.
- CARDINAL_NIC_OUT_FIFO_EN with net_ro=0:
  - Write 10 three times with 64'h1, 64'h2, 64'h3: read 11 returns 64'h3 (full and non-empty) and the third write is lost.
  - Then net_ro=1 with matching polarity: net_do sends 1 and then 2, in order.
